// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared definitions for the dac_spi serial DAC interface.
//   - state_e   : frame sequencer state encoding
//   - *_DEF     : default HALF_BIT / MSB parameter values
//   - cnt_w()   : width of the single cycle counter for a given HALF_BIT/MSB
package dac_spi_pkg;

  localparam int unsigned HALF_BIT_DEF = 2;
  localparam int unsigned MSB_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_LDAC  = 3'd5
  } state_e;

  // The longest state is SHIFT at 2*MSB*HALF_BIT cycles; the counter must reach that minus one.
  function automatic int unsigned cnt_w(input int unsigned hb, input int unsigned msb);
    return $clog2(2 * msb * hb);
  endfunction

endpackage

// File: rtl/dac_spi_shift_reg_out.sv
// shift_reg_out: MSB-wide parallel-load, MSB-first serialiser.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   load_i    : capture data_i (serial_o shows data_i[MSB-1] next cycle)
//   shift_i   : move the next lower bit to serial_o
//   clr_i     : clear the register so serial_o drives 0 (highest priority)
//   data_i    : parallel word
//   serial_o  : registered serial output (top bit of the register)
module shift_reg_out
  import dac_spi_pkg::*;
#(
  parameter int unsigned MSB = MSB_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           shift_i,
  input  logic           clr_i,
  input  logic [MSB-1:0] data_i,
  output logic           serial_o
);

  logic [MSB-1:0] sr_q, sr_d;

  // Next register value: clear beats load beats shift.
  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[MSB-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_o = sr_q[MSB-1];

endmodule

// File: rtl/dac_spi.sv
// dac_spi: SPI mode-0 transmitter for a serial DAC.
// Frame: IDLE -> SETUP -> SHIFT -> HOLD -> GAP (-> LDAC) -> IDLE, timed by one counter.
// Parameters: HALF_BIT (clocks per SCLK half-period, >=1), MSB (word width, >=2).
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   DATA_IN   : parallel word, accepted when valid && ready
//   valid     : DATA_IN is offered
//   ready     : high only in IDLE
//   CS        : active-low chip select
//   SCLK      : serial clock, idle low
//   MOSI      : serial data, MSB first, 0 while CS is high
//   DONE      : one-cycle pulse on the first CS-high cycle of a frame
//   LDAC      : (only with DAC_SPI_LDAC_EN) active-low load strobe after GAP
// Build option: define DAC_SPI_LDAC_EN to add the LDAC output and state.
module dac_spi
  import dac_spi_pkg::*;
#(
  parameter int unsigned HALF_BIT = HALF_BIT_DEF,
  parameter int unsigned MSB      = MSB_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] DATA_IN,
  input  logic           valid,
  output logic           ready,
  output logic           CS,
  output logic           SCLK,
  output logic           MOSI,
  output logic           DONE
`ifdef DAC_SPI_LDAC_EN
  ,
  output logic           LDAC
`endif
);

  localparam int unsigned CW = cnt_w(HALF_BIT, MSB);

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] HALF       = CW'(HALF_BIT);
  localparam logic [CW-1:0] PERIOD     = CW'(2 * HALF_BIT);
  localparam logic [CW-1:0] GAP_LAST   = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * MSB * HALF_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(MSB - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          load, shift, clr;
`ifdef DAC_SPI_LDAC_EN
  logic          ldac_q, ldac_d;
`endif

  // Sequencer: next state, counter and shift-register controls; outputs are
  // decoded from the next state so the registered pins line up with the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    load    = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (valid && ready_q) begin
          state_d = ST_SETUP;
          load    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // Advance MOSI with each falling SCLK edge, except after the last bit so
        // bit 0 stays on the line through HOLD.
        if ((cnt_q % PERIOD) == HALF_LAST && (cnt_q / PERIOD) != LAST_BIT) begin
          shift = 1'b1;
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
`ifdef DAC_SPI_LDAC_EN
          state_d = ST_LDAC;
`else
          state_d = ST_IDLE;
`endif
          cnt_d   = '0;
        end
      end
      ST_LDAC: begin
`ifdef DAC_SPI_LDAC_EN
        if (cnt_q == HALF_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`else
        state_d = ST_IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    cs_d    = !(state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD);
    sclk_d  = (state_d == ST_SHIFT) && ((cnt_d % PERIOD) < HALF);
    done_d  = (state_d == ST_GAP) && (cnt_d == '0);
    ready_d = (state_d == ST_IDLE);
`ifdef DAC_SPI_LDAC_EN
    ldac_d  = (state_d != ST_LDAC);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef DAC_SPI_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef DAC_SPI_LDAC_EN
      ldac_q  <= ldac_d;
`endif
    end
  end

  shift_reg_out #(
    .MSB(MSB)
  ) u_shift_reg_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .clr_i   (clr),
    .data_i  (DATA_IN),
    .serial_o(MOSI)
  );

  assign CS    = cs_q;
  assign SCLK  = sclk_q;
  assign DONE  = done_q;
  assign ready = ready_q;
`ifdef DAC_SPI_LDAC_EN
  assign LDAC  = ldac_q;
`endif

endmodule

// File: tb/tb_dac_spi.sv
// Self-checking bench for dac_spi (HALF_BIT=2, MSB=8): directed frames plus
// randomized traffic compared cycle by cycle against a frame-timeline model.
module tb_dac_spi;

  localparam int HB = 2;
  localparam int W  = 8;
  localparam int L  = HB * (2 * W + 2);
`ifdef DAC_SPI_LDAC_EN
  localparam int N  = L + 3 * HB;
  localparam int GAP_EXP = 3 * HB + 1;
`else
  localparam int N  = L + 2 * HB;
  localparam int GAP_EXP = 2 * HB + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic         ready, CS, SCLK, MOSI, DONE;
`ifdef DAC_SPI_LDAC_EN
  logic         LDAC;
`endif

  always #5 clk = ~clk;

  dac_spi #(.HALF_BIT(HB), .MSB(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .DATA_IN(DATA_IN),
    .valid  (valid),
    .ready  (ready),
    .CS     (CS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .DONE   (DONE)
`ifdef DAC_SPI_LDAC_EN
    ,
    .LDAC   (LDAC)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: k = cycles since acceptance (0 = idle), word = accepted data.
  int           k = 0;
  logic [W-1:0] m_word = '0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      started = 1'b1;
    end else if (k == 0) begin
      if (valid) begin
        k = 1;
        m_word = DATA_IN;
      end
    end else begin
      k = (k == N) ? 0 : k + 1;
    end
  end

  function automatic void model_expect(input int kk, input logic [W-1:0] wd,
                                       output bit e_cs, output bit e_sclk, output bit e_mosi,
                                       output bit e_done, output bit e_ready, output bit e_ldac);
    int p;
    int f;
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_done = 1'b0; e_ldac = 1'b1;
    e_ready = (kk == 0);
    if (kk >= 1 && kk <= L) begin
      e_cs = 1'b0;
      p = kk - 1 - HB;
      if (p >= 0 && p < 2 * W * HB) e_sclk = ((p % (2 * HB)) < HB);
      f = (p < 0) ? 0 : (p + HB) / (2 * HB);
      if (f > W - 1) f = W - 1;
      e_mosi = wd[W-1-f];
    end else if (kk == L + 1) begin
      e_done = 1'b1;
    end
    if (kk > L + 2 * HB) e_ldac = 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Measurements of the observed waveform.
  int          rises, cs_low, dones, run, last_gap, ready_viol, mosi_chg, ldac_low;
  logic [15:0] rx;
  bit          prev_sclk, prev_cs_low, prev_mosi, seen_low;

  task automatic clr_meas();
    rises = 0; cs_low = 0; dones = 0; run = 0; last_gap = 0;
    ready_viol = 0; mosi_chg = 0; ldac_low = 0; rx = '0;
    prev_sclk = SCLK; prev_cs_low = 1'b0; prev_mosi = 1'b0; seen_low = 1'b0;
  endtask

  task automatic step();
    bit ecs, esc, emo, edo, erd, eld;
    @(negedge clk);
    if (started) begin
      model_expect(k, m_word, ecs, esc, emo, edo, erd, eld);
      check("CS", int'(CS), int'(ecs));
      check("SCLK", int'(SCLK), int'(esc));
      check("MOSI", int'(MOSI), int'(emo));
      check("DONE", int'(DONE), int'(edo));
      check("ready", int'(ready), int'(erd));
`ifdef DAC_SPI_LDAC_EN
      check("LDAC", int'(LDAC), int'(eld));
`endif
    end
    if (SCLK && !prev_sclk) begin
      rises++;
      rx = {rx[14:0], MOSI};
    end
    prev_sclk = SCLK;
    if (!CS) begin
      cs_low++;
      if (prev_cs_low && MOSI != prev_mosi) mosi_chg++;
      if (run > 0 && seen_low) last_gap = run;
      run = 0;
      seen_low = 1'b1;
      if (ready) ready_viol++;
    end else begin
      run++;
    end
    prev_cs_low = !CS;
    prev_mosi = MOSI;
    if (DONE) dones++;
`ifdef DAC_SPI_LDAC_EN
    if (!LDAC) ldac_low++;
`endif
  endtask

  task automatic send(input logic [W-1:0] wd);
    bit fin;
    clr_meas();
    valid = 1'b1;
    DATA_IN = wd;
    step();
    valid = 1'b0;
    DATA_IN = W'($urandom);
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      step();
      fin = (dones > 0 && ready);
    end
    check("frame_complete", int'(fin), 1);
  endtask

  initial begin
    int ph;
    repeat (3) step();
    check("rst_CS", int'(CS), 1);
    check("rst_SCLK", int'(SCLK), 0);
    check("rst_MOSI", int'(MOSI), 0);
    check("rst_DONE", int'(DONE), 0);
    check("rst_ready", int'(ready), 1);
    rst = 1'b0;
    repeat (2) step();

    // Single 0xA5 frame.
    send(8'hA5);
    check("a5_bits", int'(rx[7:0]), 8'hA5);
    check("a5_rises", rises, 8);
    check("a5_cs_low", cs_low, 36);
    check("a5_dones", dones, 1);

    // Constant-data frames.
    send(8'h00);
    check("00_bits", int'(rx[7:0]), 8'h00);
    check("00_mosi_changes", mosi_chg, 0);
    check("00_cs_low", cs_low, 36);
    send(8'hFF);
    check("ff_bits", int'(rx[7:0]), 8'hFF);
    check("ff_mosi_changes", mosi_chg, 0);

`ifdef DAC_SPI_LDAC_EN
    send(8'h55);
    check("55_bits", int'(rx[7:0]), 8'h55);
    check("55_ldac_low", ldac_low, 2);
`endif

    // valid held high across two words.
    clr_meas();
    valid = 1'b1;
    DATA_IN = 8'h3C;
    ph = 0;
    for (int i = 0; i < 400 && ph < 4; i++) begin
      step();
      case (ph)
        0: if (!ready) begin DATA_IN = 8'hFF; ph = 1; end
        1: if (ready) ph = 2;
        2: if (!ready) begin valid = 1'b0; ph = 3; end
        default: if (dones >= 2 && ready) ph = 4;
      endcase
    end
    check("b2b_complete", ph, 4);
    check("b2b_bits", int'(rx), 16'h3CFF);
    check("b2b_rises", rises, 16);
    check("b2b_gap", last_gap, GAP_EXP);
    check("b2b_ready_low", ready_viol, 0);
    check("b2b_dones", dones, 2);

    // Reset after the third SCLK rise aborts the frame.
    clr_meas();
    valid = 1'b1;
    DATA_IN = 8'h6B;
    step();
    valid = 1'b0;
    for (int i = 0; i < 100 && rises < 3; i++) step();
    check("abort_rises", rises, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_CS", int'(CS), 1);
    check("abort_SCLK", int'(SCLK), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_DONE", int'(DONE), 0);
    repeat (20) step();
    check("abort_dones", dones, 0);
    send(8'h81);
    check("81_bits", int'(rx[7:0]), 8'h81);
    check("81_rises", rises, 8);
    check("81_dones", dones, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 2) == 0);
      DATA_IN = W'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    valid = 1'b0;
    repeat (N + 5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_spi.md
DAC_SPI -- requirements
Module: dac_spi

Interface
REQ-001 SHALL have parameter HALF_BIT, default 2: system clocks per SCLK half-period; legal values >= 1.
REQ-002 SHALL have parameter MSB, default 8: word width in bits; legal values >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port DATA_IN, input, MSB bits: parallel word to transmit.
REQ-006 SHALL have port valid, input, 1 bit: DATA_IN is offered.
REQ-007 SHALL have port ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port CS, output, 1 bit: active-low chip select.
REQ-009 SHALL have port SCLK, output, 1 bit: serial clock, idle low.
REQ-010 SHALL have port MOSI, output, 1 bit: serial data, MSB first.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 SHALL accept a word when valid && ready are both high on a rising clk edge, latching DATA_IN into the shift register.
REQ-013 SHALL assert ready only in state IDLE; valid while ready is low SHALL be ignored, with no buffering.
REQ-014 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, using one cycle counter.
REQ-015 SETUP SHALL begin the cycle after acceptance and last HALF_BIT cycles, with CS=0, SCLK=0 and MOSI=bit MSB-1.
REQ-016 SHIFT SHALL produce MSB SCLK periods; each period is HALF_BIT cycles high followed by HALF_BIT cycles low (SPI mode 0).
REQ-017 MOSI SHALL change only on SCLK falling edges, advancing to the next lower bit, and SHALL be stable across every rising edge.
REQ-018 HOLD SHALL last HALF_BIT cycles with CS=0 and SCLK=0, so CS is low for exactly HALF_BIT*(2*MSB+2) cycles.
REQ-019 On the first cycle CS returns high, the block SHALL pulse DONE=1 for exactly one cycle.
REQ-020 GAP SHALL hold CS=1 for 2*HALF_BIT cycles before entering IDLE, which guarantees the minimum inter-frame CS-high time.
REQ-021 MOSI SHALL be 0 whenever CS=1.
REQ-022 An acceptance on the same cycle GAP ends SHALL NOT occur; the earliest next acceptance is the first cycle of IDLE.

Reset
REQ-023 While rst=1 the block SHALL force state=IDLE, CS=1, SCLK=0, MOSI=0, DONE=0, ready=1, and counters and shift register to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame: CS=1 on the next edge, no DONE pulse, and the word is discarded.
REQ-025 Reset SHALL take priority over a simultaneous valid.

Configuration
REQ-026 With macro DAC_SPI_LDAC_EN defined, the block SHALL add output LDAC (1 bit, active-low, reset 1) and a state LDAC between GAP and IDLE.
REQ-027 In state LDAC, LDAC SHALL be 0 for HALF_BIT cycles while CS=1, and ready SHALL stay low until state IDLE.
REQ-028 Without DAC_SPI_LDAC_EN defined, the LDAC port and state SHALL be absent, and GAP SHALL go directly to IDLE.

Structure
REQ-029 Shared package dac_spi_pkg SHALL hold the state encoding (IDLE, SETUP, SHIFT, HOLD, GAP, LDAC) and the default HALF_BIT and MSB constants.
REQ-030 The block SHALL contain one sub-module, shift_reg_out: an MSB-wide parallel-load, MSB-first shift register with load and shift enables and a serial output.
REQ-031 The counter width SHALL be derived from HALF_BIT and MSB, not hard-coded.

Verification (HALF_BIT=2, MSB=8)
REQ-032 Drive DATA_IN=0xA5 with valid for 1 cycle -> bits sampled on SCLK rises are 1,0,1,0,0,1,0,1; CS is low 36 cycles; 8 SCLK rises; one DONE pulse.
REQ-033 Hold valid high with 0x3C then 0xFF -> two frames; CS is high for >= 4 cycles between them; ready is low throughout each frame.
REQ-034 Send 0x00 and 0xFF -> MOSI is constant during the frame; MOSI=0 whenever CS=1.
REQ-035 Assert rst for 1 cycle after the 3rd SCLK rise -> CS=1 and SCLK=0 on the next edge; no DONE; ready=1; a new 0x81 frame then transmits correctly.
REQ-036 With DAC_SPI_LDAC_EN defined, send 0x55 -> LDAC is low for 2 cycles starting after the 4 GAP cycles; ready rises only after LDAC returns high.
